uart_load_ctrl: RTL

Sequencer that owns the memory-write port while a program image streams in over the serial link, then returns the port to the CPU. Sits between the UART receiver/queue (which delivers assembled 32-bit words plus an end-of-transfer flag) and the instruction/data memories. Splits the incoming word stream into an instruction segment followed by a data segment. Holds the CPU stalled during the load and pulses a CPU restart when the load ends.

---
 rtl/uart_load_ctrl_if.sv | 27 ++
 rtl/uart_load_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/uart_load_ctrl_if.sv
// uart_load_ctrl_if: receiver, CPU write and memory-port signals around the program loader.
interface uart_load_ctrl_if #(parameter int ADDR_W = 12);
    logic              load_req;
    logic [31:0]       rx_word;
    logic              rx_valid;
    logic              rx_done;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              rx_clear;
    logic              cpu_stall;
    logic              cpu_rst;
    logic              busy;
    logic [15:0]       load_words;
    modport slave (
        input  load_req, rx_word, rx_valid, rx_done, cpu_we, cpu_addr, cpu_wdata,
        output mem_we, mem_sel, mem_addr, mem_wdata, rx_clear, cpu_stall, cpu_rst, busy, load_words
    );
    modport master (
        output load_req, rx_word, rx_valid, rx_done, cpu_we, cpu_addr, cpu_wdata,
        input  mem_we, mem_sel, mem_addr, mem_wdata, rx_clear, cpu_stall, cpu_rst, busy, load_words
    );
endinterface

// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl: owns the memory write port while a program image streams in,
// splitting it into instruction then data words, and restarts the CPU afterwards.
module uart_load_ctrl #(
    parameter int IMEM_WORDS = 4096,
    parameter int DMEM_WORDS = 4096,
    parameter int ADDR_W     = 12,
    parameter int RST_CYCLES = 4
) (
    input logic              clk,
    input logic              reset,
    uart_load_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {RUN, CLEAR, LOAD, WRITE, RESTART} state_t;
    localparam logic [31:0] IM  = 32'(IMEM_WORDS);
    localparam logic [31:0] TOT = 32'(IMEM_WORDS + DMEM_WORDS);
    localparam logic [31:0] RC  = 32'(RST_CYCLES - 1);
    state_t      state_q, state_d;
    logic [31:0] idx_q, idx_d, cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        done_q, done_d;
    logic [15:0] lw_q, lw_d;
    logic        in_dmem;
    logic [ADDR_W-1:0] dm_addr;
    function automatic logic [15:0] sat(input logic [31:0] v);
        return (v > 32'hFFFF) ? 16'hFFFF : v[15:0];
    endfunction
    assign in_dmem = idx_q >= IM;
    assign dm_addr = idx_q[ADDR_W-1:0] - IM[ADDR_W-1:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            idx_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            lw_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            done_q  <= done_d;
            lw_q    <= lw_d;
        end
    end
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        done_d        = done_q;
        lw_d          = lw_q;
        bus.mem_we    = 1'b0;
        bus.mem_sel   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            RUN: begin
                bus.mem_we    = bus.cpu_we;
                bus.mem_sel   = 1'b1;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                if (bus.load_req) state_d = CLEAR;
            end
            CLEAR: begin
                idx_d   = '0;
                done_d  = 1'b0;
                state_d = LOAD;
            end
            LOAD: begin
                // A same-cycle rx_done is remembered so the word still gets written first
                if (bus.rx_valid) begin
                    word_d  = bus.rx_word;
                    done_d  = bus.rx_done;
                    state_d = WRITE;
                end else if (bus.rx_done) begin
                    cnt_d   = '0;
                    lw_d    = sat(idx_q);
                    state_d = RESTART;
                end
            end
            WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_sel   = in_dmem;
                bus.mem_addr  = in_dmem ? dm_addr : idx_q[ADDR_W-1:0];
                bus.mem_wdata = word_q;
                idx_d         = idx_q + 32'd1;
                if (done_q || bus.rx_done || idx_d == TOT) begin
                    cnt_d   = '0;
                    lw_d    = sat(idx_d);
                    state_d = RESTART;
                end else begin
                    state_d = LOAD;
                end
            end
            RESTART: begin
                if (cnt_q == RC) state_d = RUN;
                else cnt_d = cnt_q + 32'd1;
            end
            default: state_d = RUN;
        endcase
    end
    assign bus.rx_clear   = state_q == CLEAR;
    assign bus.cpu_stall  = state_q != RUN;
    assign bus.busy       = state_q != RUN;
    assign bus.cpu_rst    = state_q == RESTART;
    assign bus.load_words = lw_q;
endmodule
